// File: rtl/uart_frame_packer_pkg.sv
// Shared types and defaults for the UART frame packer: FSM state encoding and sync bytes.
package uart_frame_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_LEN,
        ST_PAY_HI,
        ST_PAY_LO,
        ST_CSUM
    } state_t;

    localparam logic [7:0] DEF_HDR0 = 8'hA5;
    localparam logic [7:0] DEF_HDR1 = 8'h5A;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_frame_packer_if.sv
// Sample input and TX byte handshake bundle between the environment (master) and the packer (slave).
interface uart_frame_packer_if;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output sample, sample_valid, tx_ready,
        input  sample_ready, tx_data, tx_valid
    );

    modport slave (
        input  sample, sample_valid, tx_ready,
        output sample_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_frame_packer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; writes while full and reads while empty are ignored.
module uart_frame_packer_sync_fifo
    import uart_frame_packer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_frame_packer.sv
// Buffers 16-bit samples and emits framed bytes: HDR0, HDR1, LEN, payload (MSB first), XOR checksum.
module uart_frame_packer
    import uart_frame_packer_pkg::*;
#(
    parameter int         FRAME_LEN  = 8,
    parameter int         FIFO_DEPTH = 32,
    parameter logic [7:0] HDR0       = DEF_HDR0,
    parameter logic [7:0] HDR1       = DEF_HDR1
) (
    input  logic                clk,
    input  logic                reset,
    uart_frame_packer_if.slave  bus,
    output logic                busy,
    output logic                overflow
);

    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]      LEN_BYTE  = 8'(FRAME_LEN);
    localparam logic [CW-1:0]   FRAME_CNT = CW'(FRAME_LEN);

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    csum;
    logic [7:0]    samples_sent;
    logic [7:0]    samples_inc;
    logic          ack;
    logic          pop;

    uart_frame_packer_sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (bus.sample_valid),
        .rd_en (pop),
        .din   (bus.sample),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.sample_ready = !fifo_full;
    assign ack              = bus.tx_valid && bus.tx_ready;
    assign pop              = ack && (state == ST_PAY_LO) && !fifo_empty;
    assign samples_inc      = samples_sent + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (fifo_count >= FRAME_CNT) state_nxt = ST_HDR0;
            ST_HDR0:   if (ack) state_nxt = ST_HDR1;
            ST_HDR1:   if (ack) state_nxt = ST_LEN;
            ST_LEN:    if (ack) state_nxt = ST_PAY_HI;
            ST_PAY_HI: if (ack) state_nxt = ST_PAY_LO;
            ST_PAY_LO: if (ack) state_nxt = (samples_inc == LEN_BYTE) ? ST_CSUM : ST_PAY_HI;
            ST_CSUM:   if (ack) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        case (state)
            ST_HDR0:   bus.tx_data = HDR0;
            ST_HDR1:   bus.tx_data = HDR1;
            ST_LEN:    bus.tx_data = LEN_BYTE;
            ST_PAY_HI: bus.tx_data = fifo_head[15:8];
            ST_PAY_LO: bus.tx_data = fifo_head[7:0];
            ST_CSUM:   bus.tx_data = csum;
            default:   bus.tx_valid = 1'b0;
        endcase
        busy = (state != ST_IDLE);
    end

    // Headers are acknowledged but never folded into the checksum.
    always_ff @(posedge clk) begin
        if (reset || state == ST_IDLE) begin
            csum         <= 8'h00;
            samples_sent <= 8'h00;
        end else begin
            if (ack && (state == ST_LEN || state == ST_PAY_HI || state == ST_PAY_LO))
                csum <= csum_step(csum, bus.tx_data);
            if (pop) samples_sent <= samples_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                          overflow <= 1'b0;
        else if (bus.sample_valid && !bus.sample_ready)     overflow <= 1'b1;
    end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Scoreboard bench for uart_frame_packer with FRAME_LEN=2, FIFO_DEPTH=8 and a randomized TX acknowledger.
module tb_uart_frame_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic        overflow;
    logic [15:0] smp = 16'h0000;
    logic        smp_valid = 1'b0;
    logic        stall = 1'b0;
    logic        model_ready = 1'b0;
    logic        spur_ready = 1'b0;
    logic [7:0]  exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          ack_cnt = 0;

    uart_frame_packer_if bus ();

    assign bus.sample       = smp;
    assign bus.sample_valid = smp_valid;
    assign bus.tx_ready     = model_ready | spur_ready;

    uart_frame_packer #(
        .FRAME_LEN  (2),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic frame_exp(input logic [15:0] a, input logic [15:0] b, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h02);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(b[15:8]);
        exp_q.push_back(b[7:0]);
        exp_q.push_back(cs);
    endtask

    // Called at posedge+1; leaves the sample offered for exactly one edge.
    task automatic drive(input logic [15:0] s);
        smp       = s;
        smp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_valid"}, bus.tx_valid, 0);
    endtask

    // TX acknowledger: one-cycle ready pulse 3..20 cycles after a byte is presented.
    initial begin
        int w;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_valid && !stall) begin
                w = $urandom_range(3, 20);
                repeat (w - 1) @(posedge clk);
                #1;
                if (bus.tx_valid && !stall) begin
                    model_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    model_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each acknowledged byte and checks hold-while-stalled.
    initial begin
        logic       pv = 1'b0;
        logic       pa = 1'b0;
        logic       pr = 1'b1;
        logic [7:0] pd = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
            end else begin
                if (pv && !pa && !pr) begin
                    chk("hold_valid", bus.tx_valid, 1);
                    if (bus.tx_valid) chk("hold_data", bus.tx_data, pd);
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    ack_cnt++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL tx_byte: got %0h expected no byte", bus.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.tx_data !== e) begin
                            bad++;
                            $display("FAIL tx_byte: got %0h expected %0h", bus.tx_data, e);
                        end
                    end
                end
            end
            pv = bus.tx_valid;
            pa = bus.tx_valid && bus.tx_ready;
            pr = reset;
            pd = bus.tx_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sample_ready", bus.sample_ready, 1);

        // Basic frame
        frame_exp(16'h1234, 16'hABCD, 8'h42);
        drive(16'h1234);
        drive(16'hABCD);
        smp_valid = 1'b0;
        wait_done("t1");

        // Threshold: one sample short, then the completing write
        frame_exp(16'h0102, 16'h0304, 8'h06);
        drive(16'h0102);
        smp_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t2_no_frame", bus.tx_valid, 0);
        chk("t2_idle", busy, 0);
        drive(16'h0304);
        smp_valid = 1'b0;
        chk("t2_wr_plus1", bus.tx_valid, 0);
        @(posedge clk);
        #1;
        chk("t2_wr_plus2", bus.tx_valid, 1);
        chk("t2_hdr0", bus.tx_data, 8'hA5);
        wait_done("t2");

        // Burst of two frames back-to-back
        frame_exp(16'hFF00, 16'h0080, 8'h7D);
        frame_exp(16'h1357, 16'h9BDF, 8'h02);
        drive(16'hFF00);
        drive(16'h0080);
        drive(16'h1357);
        drive(16'h9BDF);
        smp_valid = 1'b0;
        wait_done("t3");

        // Fill FIFO with TX stalled, then overflow
        stall = 1'b1;
        frame_exp(16'h0001, 16'h0002, 8'h01);
        frame_exp(16'h0004, 16'h0008, 8'h0E);
        frame_exp(16'h0010, 16'h0020, 8'h32);
        frame_exp(16'h4000, 16'h8000, 8'hC2);
        drive(16'h0001);
        drive(16'h0002);
        drive(16'h0004);
        drive(16'h0008);
        drive(16'h0010);
        drive(16'h0020);
        drive(16'h4000);
        drive(16'h8000);
        smp_valid = 1'b0;
        chk("t4_ready_full", bus.sample_ready, 0);
        chk("t4_ovf_before", overflow, 0);
        drive(16'hDEAD);
        smp_valid = 1'b0;
        chk("t4_ovf_set", overflow, 1);
        chk("t4_still_full", bus.sample_ready, 0);

        // Long stall holds HDR0
        chk("t6_valid_start", bus.tx_valid, 1);
        chk("t6_data_start", bus.tx_data, 8'hA5);
        repeat (500) @(posedge clk);
        #1;
        chk("t6_valid_end", bus.tx_valid, 1);
        chk("t6_data_end", bus.tx_data, 8'hA5);
        stall = 1'b0;
        wait_done("t4");
        chk("t4_ovf_sticky", overflow, 1);

        // Spurious ready in IDLE
        spur_ready = 1'b1;
        @(posedge clk);
        #1;
        spur_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_spur_busy", busy, 0);
        chk("t6_spur_valid", bus.tx_valid, 0);

        // Reset while in PAY_LO
        frame_exp(16'h0F0F, 16'hF00F, 8'hFD);
        base = ack_cnt;
        drive(16'h0F0F);
        drive(16'hF00F);
        smp_valid = 1'b0;
        n = 0;
        while (ack_cnt < base + 4 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_reach_paylo", ack_cnt - base, 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_valid", bus.tx_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", bus.sample_ready, 1);
        chk("t5_ovf_clr", overflow, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_quiet", bus.tx_valid, 0);
        frame_exp(16'h0001, 16'h8000, 8'h83);
        drive(16'h0001);
        drive(16'h8000);
        smp_valid = 1'b0;
        wait_done("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
